// File: rtl/uart_rx_ovs_pkg.sv
// Shared constants, FSM states and helpers for the oversampling UART receiver.
package uart_rx_ovs_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int entry_w(input int data_bits);
        return data_bits + 3;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Generic synchronous FIFO; head entry is read combinationally from storage.
module uart_rx_fifo
    import uart_rx_ovs_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty_o;
    // A full FIFO still accepts a write when the head leaves this cycle.
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= wdata_i;
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver on the system clock with majority voting,
// configurable frame format and an error-tagged receive FIFO.
module uart_rx_ovs
    import uart_rx_ovs_pkg::*;
#(
    parameter int SYS_CLK_FREQ = 200_000_000,
    parameter int BAUD_RATE    = 115200,
    parameter int OVERSAMPLE   = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 sys_clk,
    input  logic                 reset_n,
    input  logic                 uart_rx_din,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_break,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_overrun,
    input  logic                 clr_overrun,
    output logic                 rx_busy
);

    localparam int DIV_RAW = SYS_CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? clog2(DIV) : 1;
    localparam int SW      = clog2(OVERSAMPLE);
    localparam int EW      = entry_w(DATA_BITS);
    localparam int M       = OVERSAMPLE / 2;

    localparam logic [SW-1:0] S_LO   = SW'(M - 1);
    localparam logic [SW-1:0] S_MID  = SW'(M);
    localparam logic [SW-1:0] S_VOTE = SW'(M + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DIV - 1);
    localparam logic [3:0]    B_DLST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    B_SLST = 4'(STOP_BITS - 1);

    logic                 sync1_q, sync2_q, prev_q;
    logic [DW-1:0]        dcnt_q, dcnt_d;
    rx_state_e            state_q, state_d;
    logic [SW-1:0]        scnt_q, scnt_d;
    logic [3:0]           bcnt_q, bcnt_d;
    logic [1:0]           smp_q, smp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 frm_q, frm_d;
    logic                 brk_q, brk_d;
    logic                 push_q, push_d;
    logic [EW-1:0]        entry_q, entry_d;
    logic                 ovr_q, ovr_d;

    logic          rxs;
    logic          tick;
    logic          start_det;
    logic          at_vote;
    logic          last;
    logic          vote;
    logic          pop;
    logic          full;
    logic          empty;
    logic [EW-1:0] head;

    assign rxs       = sync2_q;
    assign tick      = (dcnt_q == D_LAST);
    assign start_det = (state_q == ST_IDLE) & prev_q & ~rxs;
    assign at_vote   = (scnt_q == S_VOTE);
    assign last      = (scnt_q == S_LAST);
    assign vote      = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) |
                       (smp_q[1] & rxs);

    // Divider restarts on the start edge so ticks stay phase-aligned to it.
    always_comb begin
        dcnt_d = tick ? '0 : dcnt_q + 1'b1;
        if (start_det) dcnt_d = '0;
    end

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        bcnt_d  = bcnt_q;
        smp_d   = smp_q;
        shift_d = shift_q;
        par_d   = par_q;
        frm_d   = frm_q;
        brk_d   = brk_q;
        push_d  = 1'b0;
        entry_d = entry_q;
        if (state_q == ST_IDLE) begin
            if (start_det) begin
                state_d = ST_START;
                scnt_d  = '0;
                bcnt_d  = '0;
                par_d   = 1'b0;
                frm_d   = 1'b0;
                brk_d   = 1'b1;
            end
        end else if (tick) begin
            scnt_d = last ? '0 : scnt_q + 1'b1;
            if (scnt_q == S_LO)  smp_d[0] = rxs;
            if (scnt_q == S_MID) smp_d[1] = rxs;
            unique case (state_q)
                ST_START: begin
                    if (at_vote && vote) state_d = ST_IDLE;
                    else if (last)       state_d = ST_DATA;
                end
                ST_DATA: begin
                    if (at_vote) begin
                        shift_d = {vote, shift_q[DATA_BITS-1:1]};
                        brk_d   = brk_q & ~vote;
                    end
                    if (last) begin
                        if (bcnt_q == B_DLST) begin
                            bcnt_d  = '0;
                            state_d = (PARITY != PARITY_NONE) ?
                                      ST_PARITY : ST_STOP;
                        end else begin
                            bcnt_d = bcnt_q + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (at_vote) begin
                        par_d = (PARITY == PARITY_ODD) ?
                                ~(^shift_q ^ vote) : (^shift_q ^ vote);
                        brk_d = brk_q & ~vote;
                    end
                    if (last) begin
                        bcnt_d  = '0;
                        state_d = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (at_vote) begin
                        brk_d = brk_q & ~vote;
                        frm_d = frm_q | ~vote;
                        if (bcnt_q == B_SLST) begin
                            push_d  = 1'b1;
                            entry_d = {brk_d, frm_d, par_q, shift_q};
                            state_d = ST_IDLE;
                        end
                    end else if (last) begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign pop   = rx_ready & ~empty;
    // Set wins over a simultaneous clear.
    assign ovr_d = (push_q & full & ~pop) | (ovr_q & ~clr_overrun);

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            dcnt_q  <= '0;
            state_q <= ST_IDLE;
            scnt_q  <= '0;
            bcnt_q  <= '0;
            smp_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            frm_q   <= 1'b0;
            brk_q   <= 1'b0;
            push_q  <= 1'b0;
            entry_q <= '0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= uart_rx_din;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            dcnt_q  <= dcnt_d;
            state_q <= state_d;
            scnt_q  <= scnt_d;
            bcnt_q  <= bcnt_d;
            smp_q   <= smp_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            frm_q   <= frm_d;
            brk_q   <= brk_d;
            push_q  <= push_d;
            entry_q <= entry_d;
            ovr_q   <= ovr_d;
        end
    end

    uart_rx_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (sys_clk),
        .rst_ni  (reset_n),
        .push_i  (push_q),
        .wdata_i (entry_q),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign {rx_break, rx_frame_err, rx_parity_err, rx_data} = head;
    assign rx_valid   = ~empty;
    assign rx_overrun = ovr_q;
    assign rx_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Bench for uart_rx_ovs: three formats (8N1, 8E1, 8N2) at 16 cycles per bit.
module tb_uart_rx_ovs;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] din;
    logic [2:0] ready;
    logic [2:0] clr;
    logic [7:0] data [3];
    logic [2:0] perr, ferr, brk, valid, ovr, busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_rx_ovs #(
        .SYS_CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000),
        .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0),
        .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_n1 (
        .sys_clk(clk), .reset_n(reset_n), .uart_rx_din(din[0]),
        .rx_data(data[0]), .rx_parity_err(perr[0]),
        .rx_frame_err(ferr[0]), .rx_break(brk[0]),
        .rx_valid(valid[0]), .rx_ready(ready[0]),
        .rx_overrun(ovr[0]), .clr_overrun(clr[0]), .rx_busy(busy[0])
    );

    uart_rx_ovs #(
        .SYS_CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000),
        .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2),
        .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_e1 (
        .sys_clk(clk), .reset_n(reset_n), .uart_rx_din(din[1]),
        .rx_data(data[1]), .rx_parity_err(perr[1]),
        .rx_frame_err(ferr[1]), .rx_break(brk[1]),
        .rx_valid(valid[1]), .rx_ready(ready[1]),
        .rx_overrun(ovr[1]), .clr_overrun(clr[1]), .rx_busy(busy[1])
    );

    uart_rx_ovs #(
        .SYS_CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000),
        .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0),
        .STOP_BITS(2), .FIFO_DEPTH(4)
    ) u_n2 (
        .sys_clk(clk), .reset_n(reset_n), .uart_rx_din(din[2]),
        .rx_data(data[2]), .rx_parity_err(perr[2]),
        .rx_frame_err(ferr[2]), .rx_break(brk[2]),
        .rx_valid(valid[2]), .rx_ready(ready[2]),
        .rx_overrun(ovr[2]), .clr_overrun(clr[2]), .rx_busy(busy[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame bits in line order: bit0 = start, then data LSB first,
    // optional parity, then stop bits.
    function automatic logic [15:0] mk(input logic [7:0] d, input bit hp,
                                       input logic p, input logic [1:0] st);
        logic [15:0] b;
        int idx;
        b      = '1;
        b[0]   = 1'b0;
        b[8:1] = d;
        idx    = 9;
        if (hp) begin
            b[9] = p;
            idx  = 10;
        end
        b[idx]   = st[0];
        b[idx+1] = st[1];
        return b;
    endfunction

    // Reference entry {break, frame_err, parity_err, data} from line bits.
    function automatic logic [10:0] model(input logic [15:0] b, input bit hp,
                                          input bit odd, input int ns);
        logic [7:0] d;
        logic pe, fe, bk;
        int ones, sb;
        d  = b[8:1];
        pe = 1'b0;
        if (hp) begin
            ones = $countones(b[9:1]);
            pe   = odd ? (ones % 2 == 0) : (ones % 2 == 1);
        end
        sb = hp ? 10 : 9;
        fe = 1'b0;
        for (int k = 0; k < ns; k++) if (b[sb+k] == 1'b0) fe = 1'b1;
        bk = 1'b1;
        for (int i = 1; i < sb + ns; i++) if (b[i]) bk = 1'b0;
        return {bk, fe, pe, d};
    endfunction

    // Caller sits 1 time unit after a rising edge; each bit lasts 16 cycles.
    task automatic send_frame(input int sel, input int n,
                              input logic [15:0] b, input int spike);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 16; j++) begin
                din[sel] = (i == spike && j == 9) ? ~b[i] : b[i];
                @(posedge clk);
                #1;
            end
        end
        din[sel] = 1'b1;
    endtask

    task automatic check_head(input int sel, input logic [10:0] exp,
                              input string tag);
        chk({tag, "_valid"}, 32'(valid[sel]), 32'd1);
        chk(tag, {21'd0, brk[sel], ferr[sel], perr[sel], data[sel]},
            {21'd0, exp});
        ready[sel] = 1'b1;
        @(posedge clk);
        #1;
        ready[sel] = 1'b0;
    endtask

    initial begin
        logic [15:0] f;
        logic [10:0] e;
        logic [7:0]  d;
        logic        p;
        logic [1:0]  st;
        int          sel;
        int          ns;
        bit          hp;

        din     = 3'b111;
        ready   = 3'b000;
        clr     = 3'b000;
        reset_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flags", {20'd0, ovr, perr, ferr, brk}, 32'd0);
        chk("rst_data", {8'd0, data[0], data[1], data[2]}, 32'd0);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // 8N1 0xA5: valid rises 2 cycles after the final stop vote.
        fork
            send_frame(0, 10, mk(8'hA5, 0, 1'b0, 2'b11), -1);
            begin
                repeat (157) @(posedge clk);
                #1;
                chk("lat_early", 32'(valid[0]), 32'd0);
                @(posedge clk);
                #1;
                chk("lat_ontime", 32'(valid[0]), 32'd1);
            end
        join
        repeat (4) @(posedge clk);
        #1;
        check_head(0, {3'b000, 8'hA5}, "n1_a5");
        chk("n1_empty", 32'(valid[0]), 32'd0);
        ready[0] = 1'b1;
        @(posedge clk);
        #1;
        ready[0] = 1'b0;
        chk("ready_idle", 32'(valid[0]), 32'd0);

        // 8E1 parity error and clean parity.
        send_frame(1, 11, mk(8'h03, 1, 1'b1, 2'b11), -1);
        repeat (4) @(posedge clk);
        #1;
        check_head(1, {3'b001, 8'h03}, "e1_perr");
        send_frame(1, 11, mk(8'h03, 1, 1'b0, 2'b11), -1);
        repeat (4) @(posedge clk);
        #1;
        check_head(1, {3'b000, 8'h03}, "e1_pok");

        // 8N2 bad second stop bit, then a 12-bit-time break.
        send_frame(2, 11, mk(8'h5A, 0, 1'b0, 2'b01), -1);
        repeat (4) @(posedge clk);
        #1;
        check_head(2, {3'b010, 8'h5A}, "n2_ferr");
        send_frame(2, 12, 16'h0000, -1);
        repeat (4) @(posedge clk);
        #1;
        check_head(2, {3'b110, 8'h00}, "n2_break");
        chk("n2_break_one", 32'(valid[2]), 32'd0);

        // Short glitch is rejected as a false start.
        din[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("glitch_busy", 32'(busy[0]), 32'd1);
        @(posedge clk);
        #1;
        din[0] = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("glitch_idle", 32'(busy[0]), 32'd0);
        chk("glitch_none", 32'(valid[0]), 32'd0);

        // One-cycle spike inside the vote window of data bit 3.
        send_frame(0, 10, mk(8'h5A, 0, 1'b0, 2'b11), 4);
        repeat (4) @(posedge clk);
        #1;
        check_head(0, {3'b000, 8'h5A}, "spike");

        // Overrun: five frames into a four-entry FIFO.
        for (int i = 1; i <= 5; i++)
            send_frame(0, 10, mk(8'(i), 0, 1'b0, 2'b11), -1);
        repeat (4) @(posedge clk);
        #1;
        chk("ovr_set", 32'(ovr[0]), 32'd1);
        for (int i = 1; i <= 4; i++)
            check_head(0, {3'b000, 8'(i)}, "ovr_drain");
        chk("ovr_drained", 32'(valid[0]), 32'd0);
        chk("ovr_sticky", 32'(ovr[0]), 32'd1);
        clr[0] = 1'b1;
        @(posedge clk);
        #1;
        clr[0] = 1'b0;
        chk("ovr_clr", 32'(ovr[0]), 32'd0);

        // Randomized frames against the reference model.
        for (int i = 0; i < 12; i++) begin
            sel = i % 3;
            hp  = (sel == 1);
            ns  = (sel == 2) ? 2 : 1;
            d   = 8'($urandom);
            p   = 1'($urandom);
            st  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            f   = mk(d, hp, p, st);
            e   = model(f, hp, 1'b0, ns);
            send_frame(sel, 9 + int'(hp) + ns, f, -1);
            repeat (4) @(posedge clk);
            #1;
            check_head(sel, e, "rand");
            chk("rand_empty", 32'(valid[sel]), 32'd0);
        end

        // Reset during data bit 3 with one entry already queued.
        send_frame(0, 10, mk(8'h77, 0, 1'b0, 2'b11), -1);
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_valid", 32'(valid[0]), 32'd1);
        fork
            send_frame(0, 10, mk(8'h3C, 0, 1'b0, 2'b11), -1);
            begin
                repeat (72) @(posedge clk);
                #1;
                reset_n = 1'b0;
                #1;
                chk("midrst_out",
                    {18'd0, data[0], perr[0], ferr[0], brk[0],
                     valid[0], ovr[0], busy[0]}, 32'd0);
            end
        join
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_empty", 32'(valid[0]), 32'd0);
        send_frame(0, 10, mk(8'h3C, 0, 1'b0, 2'b11), -1);
        repeat (4) @(posedge clk);
        #1;
        check_head(0, {3'b000, 8'h3C}, "post_rst_3c");
        chk("post_rst_done", 32'(valid[0]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
